// File: rtl/ula_multiciclo_if.sv
// ============================================================================
// Module : ula_multiciclo_if
// Brief  : Start/done handshake and operand/result bus of the multi-cycle ALU.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ula_multiciclo_if #(
  parameter int W = 32
) ();
  logic         inicio;
  logic [3:0]   OP;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] S;
  logic [W-1:0] HI;
  logic         Z;
  logic         ocupado;
  logic         pronto;
  logic         div_zero;

  modport master (
    output inicio, OP, A, B,
    input  S, HI, Z, ocupado, pronto, div_zero
  );

  modport slave (
    input  inicio, OP, A, B,
    output S, HI, Z, ocupado, pronto, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/ula_multiciclo.sv
// ============================================================================
// Module : ula_multiciclo
// Brief  : Multi-cycle MIPS ALU with iterative unsigned MULTU/DIVU and HI reg.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ula_multiciclo #(
  parameter int W = 32
) (
  input  wire logic          clock,
  input  wire logic          reset,
  ula_multiciclo_if.slave    bus
);
  localparam int             CW       = $clog2(W);
  localparam logic [CW-1:0]  C_LAST   = CW'(W - 1);
  localparam logic [3:0]     C_MULTU  = 4'd4;
  localparam logic [3:0]     C_DIVU   = 4'd5;

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_acc, r_q, r_mcand;
  logic          r_div;
  logic [W-1:0]  r_s, r_hi;
  logic          r_z, r_pronto, r_divzero;

  logic          w_single, w_divz, w_start, w_last;
  logic [CW-1:0] w_sh;
  logic [W-1:0]  w_alu;
  logic [W:0]    w_sum, w_shl, w_diff, w_madd;
  logic [W-1:0]  w_acc_nxt, w_q_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_single    = 1'b0;
    w_divz      = 1'b0;
    w_start     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.inicio) begin
          if (bus.OP == C_MULTU || (bus.OP == C_DIVU && bus.B != '0)) begin
            w_start     = 1'b1;
            w_state_nxt = CALC;
          end else if (bus.OP == C_DIVU) begin
            w_divz = 1'b1;
          end else begin
            w_single = 1'b1;
          end
        end
      end
      CALC: begin
        if (r_cnt == C_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_sh = bus.B[CW-1:0];

  always_comb begin
    w_alu = '0;
    case (bus.OP)
      4'd0:    w_alu = bus.A & bus.B;
      4'd1:    w_alu = bus.A | bus.B;
      4'd2:    w_alu = bus.A + bus.B;
      4'd3:    w_alu = bus.A;
      4'd6:    w_alu = bus.A - bus.B;
      4'd7:    w_alu = {{(W-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      4'd8:    w_alu = {{(W-1){1'b0}}, (bus.A < bus.B)};
      4'd9:    w_alu = bus.A << w_sh;
      4'd10:   w_alu = bus.A >> w_sh;
      4'd11:   w_alu = $signed(bus.A) >>> w_sh;
      4'd12:   w_alu = ~(bus.A | bus.B);
      4'd13:   w_alu = bus.A ^ bus.B;
      default: w_alu = '0;
    endcase
  end

  // Multiply: {acc,q} shifts right with conditional add of the multiplicand.
  // Divide: restoring step, remainder in acc, dividend shifts out of q.
  always_comb begin
    w_sum  = {1'b0, r_acc} + {1'b0, r_mcand};
    w_madd = r_q[0] ? w_sum : {1'b0, r_acc};
    w_shl  = {r_acc, r_q[W-1]};
    w_diff = w_shl - {1'b0, r_mcand};
    if (r_div) begin
      if (!w_diff[W]) begin
        w_acc_nxt = w_diff[W-1:0];
        w_q_nxt   = {r_q[W-2:0], 1'b1};
      end else begin
        w_acc_nxt = w_shl[W-1:0];
        w_q_nxt   = {r_q[W-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_madd[W:1];
      w_q_nxt   = {w_madd[0], r_q[W-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_mcand   <= '0;
      r_div     <= 1'b0;
      r_s       <= '0;
      r_hi      <= '0;
      r_z       <= 1'b1;
      r_pronto  <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_pronto <= w_single | w_divz | w_last;
      if (w_single) begin
        r_s       <= w_alu;
        r_z       <= (w_alu == '0);
        r_divzero <= 1'b0;
      end
      if (w_divz) begin
        r_s       <= '1;
        r_hi      <= bus.A;
        r_z       <= 1'b0;
        r_divzero <= 1'b1;
      end
      if (w_start) begin
        r_acc     <= '0;
        r_q       <= bus.A;
        r_mcand   <= bus.B;
        r_div     <= (bus.OP == C_DIVU);
        r_cnt     <= '0;
        r_divzero <= 1'b0;
      end
      if (r_state == CALC) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_s  <= w_q_nxt;
        r_hi <= w_acc_nxt;
        r_z  <= (w_q_nxt == '0);
      end
    end
  end

  assign bus.S        = r_s;
  assign bus.HI       = r_hi;
  assign bus.Z        = r_z;
  assign bus.ocupado  = (r_state == CALC);
  assign bus.pronto   = r_pronto;
  assign bus.div_zero = r_divzero;
endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
// ============================================================================
// Module : tb_ula_multiciclo
// Brief  : Self-checking bench for ula_multiciclo against an arithmetic model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ula_multiciclo;
  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [31:0] exp_hi;

  ula_multiciclo_if #(.W(W)) bus ();

  ula_multiciclo #(.W(W)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the operation table written with plain arithmetic.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, b,
                                inout logic [31:0] hi, output logic [31:0] s,
                                output logic dz);
    logic [63:0] p;
    int sh;
    sh = int'(b % 32);
    dz = 1'b0;
    s  = '0;
    case (op)
      4'd0:  s = a & b;
      4'd1:  s = a | b;
      4'd2:  s = a + b;
      4'd3:  s = a;
      4'd4:  begin p = {32'd0, a} * {32'd0, b}; s = p[31:0]; hi = p[63:32]; end
      4'd5:  begin
        if (b == 0) begin s = 32'hFFFF_FFFF; hi = a; dz = 1'b1; end
        else begin s = a / b; hi = a % b; end
      end
      4'd6:  s = a - b;
      4'd7:  s = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8:  s = (a < b) ? 32'd1 : 32'd0;
      4'd9:  s = a << sh;
      4'd10: s = a >> sh;
      4'd11: s = $signed(a) >>> sh;
      4'd12: s = ~(a | b);
      4'd13: s = a ^ b;
      default: s = '0;
    endcase
  endfunction

  task automatic do_accept(input logic [3:0] op, input logic [31:0] a, b);
    bus.inicio = 1'b1;
    bus.OP     = op;
    bus.A      = a;
    bus.B      = b;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    bus.OP     = 4'($urandom);
    bus.A      = $urandom;
    bus.B      = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.ocupado === 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.inicio = 1'b0; bus.OP = '0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.S !== 32'd0 || bus.HI !== 32'd0 || bus.Z !== 1'b1 ||
        bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: S=%h HI=%h Z=%b ocup=%b pronto=%b dz=%b, required 0 0 1 0 0 0",
               bus.S, bus.HI, bus.Z, bus.ocupado, bus.pronto, bus.div_zero);
    end
    rst_n = 1'b1;
    exp_hi = '0;
  endtask

  task automatic test_back_to_back;
    bus.inicio = 1'b1; bus.OP = 4'd2; bus.A = 32'hFFFF_FFFF; bus.B = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (bus.S !== 32'd0 || bus.Z !== 1'b1 || bus.pronto !== 1'b1) begin
      errors++;
      $display("FAIL b2b_add: S=%h Z=%b pronto=%b, required 00000000 1 1", bus.S, bus.Z, bus.pronto);
    end
    bus.OP = 4'd11; bus.A = 32'h8000_0000; bus.B = 32'h24;
    @(posedge clk); #1;
    bus.inicio = 1'b0;
    checks++;
    if (bus.S !== 32'hF800_0000 || bus.Z !== 1'b0 || bus.pronto !== 1'b1 || bus.HI !== exp_hi) begin
      errors++;
      $display("FAIL b2b_sra: S=%h Z=%b pronto=%b HI=%h, required f8000000 0 1 %h",
               bus.S, bus.Z, bus.pronto, bus.HI, exp_hi);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pronto !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_pronto: pronto=%b, required 0", bus.pronto);
    end
  endtask

  task automatic test_compare;
    do_accept(4'd7, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (bus.S !== 32'd1 || bus.HI !== exp_hi || bus.pronto !== 1'b1) begin
      errors++;
      $display("FAIL slt: S=%h HI=%h pronto=%b, required 00000001 %h 1", bus.S, bus.HI, bus.pronto, exp_hi);
    end
    do_accept(4'd8, 32'hFFFF_FFFF, 32'd1);
    checks++;
    if (bus.S !== 32'd0 || bus.Z !== 1'b1 || bus.HI !== exp_hi) begin
      errors++;
      $display("FAIL sltu: S=%h Z=%b HI=%h, required 00000000 1 %h", bus.S, bus.Z, bus.HI, exp_hi);
    end
  endtask

  task automatic test_multu;
    int n;
    do_accept(4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    while (bus.ocupado === 1'b1 && n < 40) begin
      bus.inicio = (n == 5);
      bus.OP     = 4'd2;
      @(posedge clk); #1;
      n++;
    end
    bus.inicio = 1'b0;
    exp_hi = 32'hFFFF_FFFE;
    checks++;
    if (n !== 32 || bus.pronto !== 1'b1) begin
      errors++;
      $display("FAIL multu_latency: busy=%0d pronto=%b, required 32 1", n, bus.pronto);
    end
    checks++;
    if (bus.HI !== 32'hFFFF_FFFE || bus.S !== 32'h0000_0001 || bus.Z !== 1'b0) begin
      errors++;
      $display("FAIL multu_result: HI=%h S=%h Z=%b, required fffffffe 00000001 0", bus.HI, bus.S, bus.Z);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.pronto !== 1'b0 || bus.ocupado !== 1'b0 || bus.S !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_ignored_inicio: pronto=%b ocup=%b S=%h, required 0 0 00000001",
               bus.pronto, bus.ocupado, bus.S);
    end
  endtask

  task automatic test_divu;
    int n;
    do_accept(4'd5, 32'd100, 32'd7);
    wait_done(n);
    exp_hi = 32'd2;
    checks++;
    if (n !== 32 || bus.pronto !== 1'b1 || bus.S !== 32'd14 || bus.HI !== 32'd2 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL divu: busy=%0d pronto=%b S=%0d HI=%0d dz=%b, required 32 1 14 2 0",
               n, bus.pronto, bus.S, bus.HI, bus.div_zero);
    end
  endtask

  task automatic test_divzero;
    int n;
    do_accept(4'd5, 32'd5, 32'd0);
    wait_done(n);
    exp_hi = 32'd5;
    checks++;
    if (n !== 0 || bus.pronto !== 1'b1 || bus.S !== 32'hFFFF_FFFF || bus.HI !== 32'd5 ||
        bus.div_zero !== 1'b1 || bus.Z !== 1'b0) begin
      errors++;
      $display("FAIL divzero: busy=%0d pronto=%b S=%h HI=%h dz=%b Z=%b, required 0 1 ffffffff 00000005 1 0",
               n, bus.pronto, bus.S, bus.HI, bus.div_zero, bus.Z);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.div_zero !== 1'b1 || bus.pronto !== 1'b0) begin
      errors++;
      $display("FAIL divzero_hold: dz=%b pronto=%b, required 1 0", bus.div_zero, bus.pronto);
    end
    do_accept(4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF);
    checks++;
    if (bus.div_zero !== 1'b0 || bus.S !== 32'h00F0_1234 || bus.HI !== 32'd5) begin
      errors++;
      $display("FAIL and_clears_dz: dz=%b S=%h HI=%h, required 0 00f01234 00000005",
               bus.div_zero, bus.S, bus.HI);
    end
  endtask

  task automatic test_random;
    logic [3:0]  op;
    logic [31:0] a, b, es;
    logic        edz, multi;
    int          n;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
      if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 3);
      multi = (op == 4'd4) || (op == 4'd5 && b != 0);
      model(op, a, b, exp_hi, es, edz);
      do_accept(op, a, b);
      wait_done(n);
      checks++;
      if (bus.pronto !== 1'b1 || n !== (multi ? 32 : 0)) begin
        errors++;
        $display("FAIL rand_latency[%0d] op=%0d: busy=%0d pronto=%b, required %0d 1",
                 i, op, n, bus.pronto, multi ? 32 : 0);
      end
      checks++;
      if (bus.S !== es || bus.HI !== exp_hi || bus.Z !== (es == 0) || bus.div_zero !== edz) begin
        errors++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: S=%h HI=%h Z=%b dz=%b, required %h %h %b %b",
                 i, op, a, b, bus.S, bus.HI, bus.Z, bus.div_zero, es, exp_hi, (es == 0), edz);
      end
    end
  endtask

  task automatic test_midcalc_reset;
    int seen;
    do_accept(4'd4, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.S !== 32'd0 || bus.HI !== 32'd0 || bus.Z !== 1'b1 ||
        bus.ocupado !== 1'b0 || bus.pronto !== 1'b0 || bus.div_zero !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_reset: S=%h HI=%h Z=%b ocup=%b pronto=%b dz=%b, required 0 0 1 0 0 0",
               bus.S, bus.HI, bus.Z, bus.ocupado, bus.pronto, bus.div_zero);
    end
    rst_n = 1'b1;
    exp_hi = '0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.pronto !== 1'b0 || bus.ocupado !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL midcalc_no_pronto: active_cycles=%0d, required 0", seen);
    end
    do_accept(4'd2, 32'd40, 32'd2);
    checks++;
    if (bus.pronto !== 1'b1 || bus.S !== 32'd42 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_add: pronto=%b S=%0d HI=%h, required 1 42 00000000",
               bus.pronto, bus.S, bus.HI);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_back_to_back();
    test_compare();
    test_multu();
    test_divu();
    test_divzero();
    test_random();
    test_midcalc_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ula_multiciclo.md
# ula_multiciclo

Parametrised multi-cycle ALU for the MIPS datapath. It is the successor of the 32-bit combinational ULA. It adds a registered start/done handshake, configurable width, unsigned iterative multiply and divide with a HI result register, signed/unsigned compare and arithmetic shift. The control unit drives it and stalls on `ocupado` while a multiply or divide is in flight.

## Interface
- `W`, default 32: datapath width. Must be a power of two, ≥ 8.
- `clock` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `inicio` in 1: start request. Sampled only in IDLE.
- `OP` in 4: operation select, latched on accept.
- `A` in W: operand A, latched on accept.
- `B` in W: operand B, latched on accept.
- `S` out W: result; the LO word for MULTU and DIVU.
- `HI` out W: MULTU upper product or DIVU remainder. Holds its value for all other ops.
- `Z` out 1: 1 when the S value being loaded is 0. Updated together with S.
- `ocupado` out 1: a multi-cycle operation is in progress.
- `pronto` out 1: one-cycle pulse; S/HI/Z/`div_zero` are valid from this cycle onward.
- `div_zero` out 1: the last completed operation was DIVU with B = 0.

## Operation
- Opcodes (operands are the latched values; `sh` = B[log2(W)-1:0]):
  - 0 AND
  - 1 OR
  - 2 ADD (wraps modulo 2^W)
  - 3 PASS A
  - 4 MULTU: {HI,S} = A*B, unsigned, 2W-bit product
  - 5 DIVU: S = A/B, HI = A%B, unsigned
  - 6 SUB (wraps)
  - 7 SLT: signed, S = 1 or 0
  - 8 SLTU: unsigned
  - 9 SLL by `sh`
  - 10 SRL by `sh`
  - 11 SRA by `sh`
  - 12 NOR
  - 13 XOR
  - 14, 15: S = 0
- No overflow detection on ADD/SUB.
- Upper bits of B above `sh` are ignored for shifts.
- State machine:
  - IDLE: `ocupado` = 0. When `inicio` = 1, latch OP/A/B.
    - Single-cycle ops (all except 4 and 5): load S/Z (HI unchanged), pulse `pronto`, remain in IDLE.
    - DIVU with B = 0: complete immediately with S = all ones, HI = A, `div_zero` = 1. Pulse `pronto`, remain in IDLE.
    - MULTU, or DIVU with B ≠ 0: clear the iteration counter and go to CALC.
  - CALC: `ocupado` = 1. Performs one shift-add (MULTU) or restoring shift-subtract (DIVU) step per cycle, W steps in total, counter 0..W-1.
    - After step W-1: load S/HI/Z, pulse `pronto`, go to IDLE.
- `div_zero` is cleared by any other accepted operation. It is set only on a divide-by-zero completion.
- `inicio` in CALC is ignored. No queueing; the requester must retry after `pronto`.
- `inicio` may be asserted in the cycle `pronto` is high. It is accepted because the block is in IDLE.
- A/B/OP changes after accept have no effect.
- S, HI, Z and `div_zero` hold their values between completions.
- Reset low at any edge, including mid-CALC: abort the operation and go to IDLE with S = 0, HI = 0, Z = 1, `ocupado` = 0, `pronto` = 0, `div_zero` = 0, counter = 0. Reset takes priority over `inicio`.

## Timing
- Accept at edge k:
  - Single-cycle op: S/Z/`pronto` are valid in the cycle after edge k (latency 1).
  - Divide-by-zero: same as single-cycle, latency 1.
  - MULTU / DIVU with B ≠ 0: `ocupado` = 1 in the cycles after edges k .. k+W-1. Result and `pronto` appear after edge k+W (latency W). `ocupado` = 0 in the `pronto` cycle.
- `pronto` is never high for two consecutive cycles unless a new single-cycle op was accepted in the `pronto` cycle, in which case back-to-back pulses are legal.
- Throughput:
  - One single-cycle op per clock.
  - One multiply or divide per W+1 clocks, counting the accepting cycle.

## Test plan
- Reset: hold `reset` = 0 for 2 edges. Expect S = 0, HI = 0, Z = 1, `ocupado` = 0, `pronto` = 0, `div_zero` = 0.
- Back-to-back single-cycle ops (W = 32):
  - ADD 0xFFFFFFFF + 1 -> S = 0, Z = 1.
  - Next cycle, SRA 0x80000000 by B = 0x24 (sh = 4) -> S = 0xF8000000, Z = 0.
  - Expect `pronto` high in both cycles.
- Compares with A = 0xFFFFFFFF, B = 1: SLT -> S = 1; SLTU -> S = 0. HI unchanged throughout.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF:
  - `ocupado` = 1 for exactly 32 cycles, `pronto` on the 32nd edge.
  - HI = 0xFFFFFFFE, S = 0x00000001.
  - An `inicio` with ADD pulsed mid-CALC is ignored.
- DIVU 100 / 7 -> S = 14, HI = 2, `div_zero` = 0, latency 32.
- DIVU 5 / 0 -> latency 1, S = 0xFFFFFFFF, HI = 5, `div_zero` = 1. A following AND clears `div_zero`.
- Mid-CALC reset: start MULTU, assert `reset` = 0 at iteration 10. Expect all outputs at their reset values and no `pronto`. A new ADD accepted afterwards completes in 1 cycle.
